mc_datapath: RTL

//  Multi-cycle MIPS datapath. It is the direct consumer of the control FSM's per-state strobes.

---
 rtl/mc_pkg.sv | 67 ++++++
 rtl/mc_regfile.sv | 42 ++++
 rtl/mc_datapath.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS datapath and its control FSM.
package mc_pkg;

   // Primary opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALUOp strobe encodings
   localparam logic [1:0] ALUOP_ADD     = 2'b00;
   localparam logic [1:0] ALUOP_SUB     = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
   localparam logic [1:0] ALUOP_ADD_ALT = 2'b11;

   // ALUSrcB strobe encodings
   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // PCSource strobe encodings
   localparam logic [1:0] PCSRC_ALU     = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT  = 2'b01;
   localparam logic [1:0] PCSRC_JUMP    = 2'b10;
   localparam logic [1:0] PCSRC_ALU_ALT = 2'b11;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT,
      ALU_ZERO
   } alu_ctl_e;

   // ALU control decode from the FSM's ALUOp and the instruction funct field
   function automatic alu_ctl_e alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
      alu_ctl_e ctl;
      ctl = ALU_ADD;
      case (alu_op)
         ALUOP_ADD, ALUOP_ADD_ALT: ctl = ALU_ADD;
         ALUOP_SUB:                ctl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  ctl = ALU_ADD;
               FN_SUB:  ctl = ALU_SUB;
               FN_AND:  ctl = ALU_AND;
               FN_OR:   ctl = ALU_OR;
               FN_SLT:  ctl = ALU_SLT;
               default: ctl = ALU_ZERO;
            endcase
         end
         default: ctl = ALU_ADD;
      endcase
      return ctl;
   endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two combinational read ports, one write port, $0 hardwired to zero.
module mc_regfile
   import mc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2
);

   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];

   // Next register contents: single write, writes to $0 dropped
   always_comb begin
      regs_d = regs_q;
      if (we && (waddr != 5'd0)) begin
         regs_d[waddr] = wdata;
      end
   end

   // Register storage with synchronous clear
   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read ports return the pre-write value; $0 always reads zero
   always_comb begin
      rdata1 = (raddr1 == 5'd0) ? '0 : regs_q[raddr1];
      rdata2 = (raddr2 == 5'd0) ? '0 : regs_q[raddr2];
   end

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, register file, ALU and operand muxes.
module mc_datapath
   import mc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        IorD,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        MemToReg,
   input  logic        IRWrite,
   input  logic        ALUSrcA,
   input  logic        RegWrite,
   input  logic        RegDst,
   input  logic        PCSel,
   input  logic [1:0]  PCSource,
   input  logic [1:0]  ALUSrcB,
   input  logic [1:0]  ALUOp,
   output logic [5:0]  Op,
   output logic        Zero,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_re,
   output logic        mem_we,
   input  logic [31:0] mem_rdata,
   output logic [31:0] pc_out
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] mdr_q, mdr_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] aluout_q, aluout_d;

   logic [31:0] rs_data, rt_data;
   logic [31:0] imm_sext;
   logic [31:0] src_a, src_b;
   logic [31:0] alu_result;
   logic [31:0] jump_target;
   logic [31:0] pc_next;
   logic        pc_en;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   alu_ctl_e    alu_ctl;

   mc_regfile u_rf (
      .clk    (clk),
      .reset  (reset),
      .we     (RegWrite),
      .raddr1 (ir_q[25:21]),
      .raddr2 (ir_q[20:16]),
      .waddr  (rf_waddr),
      .wdata  (rf_wdata),
      .rdata1 (rs_data),
      .rdata2 (rt_data)
   );

   // Register-file write address and data selection
   always_comb begin
      rf_waddr = RegDst ? ir_q[15:11] : ir_q[20:16];
      rf_wdata = MemToReg ? mdr_q : aluout_q;
   end

   // ALU operand selection
   always_comb begin
      imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
      src_a    = ALUSrcA ? a_q : pc_q;
      case (ALUSrcB)
         SRCB_B:       src_b = b_q;
         SRCB_FOUR:    src_b = 32'd4;
         SRCB_IMM:     src_b = imm_sext;
         SRCB_IMM_SH2: src_b = {imm_sext[29:0], 2'b00};
         default:      src_b = b_q;
      endcase
   end

   // ALU control decode and ALU
   always_comb begin
      alu_ctl = alu_decode(ALUOp, ir_q[5:0]);
      case (alu_ctl)
         ALU_ADD:  alu_result = src_a + src_b;
         ALU_SUB:  alu_result = src_a - src_b;
         ALU_AND:  alu_result = src_a & src_b;
         ALU_OR:   alu_result = src_a | src_b;
         ALU_SLT:  alu_result = {31'd0, ($signed(src_a) < $signed(src_b))};
         ALU_ZERO: alu_result = '0;
         default:  alu_result = '0;
      endcase
      Zero = (alu_result == '0);
   end

   // Next-PC selection; PCSource 01 with Zero is the beq path and merges with PCSel into one load
   always_comb begin
      jump_target = {pc_q[31:28], ir_q[25:0], 2'b00};
      case (PCSource)
         PCSRC_ALU:     pc_next = alu_result;
         PCSRC_ALUOUT:  pc_next = aluout_q;
         PCSRC_JUMP:    pc_next = jump_target;
         PCSRC_ALU_ALT: pc_next = alu_result;
         default:       pc_next = alu_result;
      endcase
      pc_en = PCSel | ((PCSource == PCSRC_ALUOUT) & Zero);
   end

   // Next values for the architectural registers
   always_comb begin
      pc_d     = pc_en ? pc_next : pc_q;
      ir_d     = IRWrite ? mem_rdata : ir_q;
      mdr_d    = mem_rdata;
      a_d      = rs_data;
      b_d      = rt_data;
      aluout_d = alu_result;
   end

   // Architectural registers with synchronous reset taking priority over every load
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         mdr_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         aluout_q <= '0;
      end else begin
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         mdr_q    <= mdr_d;
         a_q      <= a_d;
         b_q      <= b_d;
         aluout_q <= aluout_d;
      end
   end

   // Memory port and status outputs
   always_comb begin
      mem_addr  = IorD ? aluout_q : pc_q;
      mem_wdata = b_q;
      mem_re    = MemRead;
      mem_we    = MemWrite;
      Op        = ir_q[31:26];
      pc_out    = pc_q;
   end

endmodule
